// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for signal_edge_detector.
//   DEF_WIDTH / DEF_CNT_W : default parameter values of the top
//   SYNC_STAGES           : flop depth of the optional input synchronizer
//   sat_inc()             : saturating +1 for counters up to 32 bits wide
package edge_det_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam int DEF_CNT_W   = 8;
  localparam int SYNC_STAGES = 2;

  // Counters are kept at their native width by the caller; the helper works on a
  // 32-bit container and the caller truncates the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_v) ? max_v : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/edge_det_sync.sv
// Per-bit multi-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears every stage
//   d     : asynchronous levels
//   q     : levels re-timed to clk, SYNC_STAGES cycles later
module edge_det_sync
  import edge_det_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/signal_edge_detector.sv
// Rising/falling/any-edge detector for a vector of level signals, with per-bit
// saturating rising- and falling-edge counters.
//   clk, reset        : single clock, synchronous active-high reset
//   signal            : WIDTH level inputs
//   cnt_clr           : synchronous clear of all counters (wins over increments)
//   posedge_detected  : one-cycle pulse per bit on 0->1
//   negedge_detected  : one-cycle pulse per bit on 1->0
//   anyedge_detected  : OR of the two above
//   pos_count         : per-bit rising-edge counts, bit i at [i*CNT_W +: CNT_W]
//   neg_count         : per-bit falling-edge counts, same packing
// Build option: define EDGE_DET_SYNC_EN to insert a 2-flop synchronizer ahead of
// the detector (adds 2 cycles of latency, for asynchronous sources).
module signal_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       signal,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       posedge_detected,
  output logic [WIDTH-1:0]       negedge_detected,
  output logic [WIDTH-1:0]       anyedge_detected,
  output logic [WIDTH*CNT_W-1:0] pos_count,
  output logic [WIDTH*CNT_W-1:0] neg_count
);

  logic [WIDTH-1:0] s, prev, pos_ev, neg_ev;
  logic             primed;

`ifdef EDGE_DET_SYNC_EN
  edge_det_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (signal),
    .q     (s)
  );
`else
  assign s = signal;
`endif

  // primed masks the first sample after reset, where prev is not yet valid.
  assign pos_ev = {WIDTH{primed}} &  s & ~prev;
  assign neg_ev = {WIDTH{primed}} & ~s &  prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev             <= '0;
      primed           <= 1'b0;
      posedge_detected <= '0;
      negedge_detected <= '0;
      anyedge_detected <= '0;
    end else begin
      prev             <= s;
      primed           <= 1'b1;
      posedge_detected <= pos_ev;
      negedge_detected <= neg_ev;
      anyedge_detected <= pos_ev | neg_ev;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    logic [CNT_W-1:0] pc, nc;
    logic [31:0]      pc_nxt, nc_nxt;

    assign pc_nxt = sat_inc(32'(pc), CNT_W);
    assign nc_nxt = sat_inc(32'(nc), CNT_W);

    always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
        pc <= '0;
        nc <= '0;
      end else begin
        if (pos_ev[i]) pc <= pc_nxt[CNT_W-1:0];
        if (neg_ev[i]) nc <= nc_nxt[CNT_W-1:0];
      end
    end

    assign pos_count[i*CNT_W +: CNT_W] = pc;
    assign neg_count[i*CNT_W +: CNT_W] = nc;
  end

endmodule

// File: tb/tb_signal_edge_detector.sv
module tb_signal_edge_detector;

`ifdef EDGE_DET_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset, cnt_clr;
  always #5 clk = ~clk;

  // unit A: WIDTH=1, CNT_W=8
  logic       sig_a;
  logic       pos_a, neg_a, any_a;
  logic [7:0] pc_a, nc_a;
  // unit B: WIDTH=4, CNT_W=2
  logic [3:0] sig_b, pos_b, neg_b, any_b;
  logic [7:0] pc_b, nc_b;

  signal_edge_detector #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .signal(sig_a), .cnt_clr(cnt_clr),
    .posedge_detected(pos_a), .negedge_detected(neg_a), .anyedge_detected(any_a),
    .pos_count(pc_a), .neg_count(nc_a));

  signal_edge_detector #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .signal(sig_b), .cnt_clr(cnt_clr),
    .posedge_detected(pos_b), .negedge_detected(neg_b), .anyedge_detected(any_b),
    .pos_count(pc_b), .neg_count(nc_b));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, land 1 time unit after the last one
  task automatic step(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cnt_clr = 1'b0; sig_a = 1'b1; sig_b = 4'hF;
    step(2);
    chk("rst_pos_a", 32'(pos_a), 0);
    chk("rst_any_b", 32'(any_b), 0);
    chk("rst_pc_a",  32'(pc_a),  0);
    reset = 1'b0;
    step(1);
    chk("prime_pos_a", 32'(pos_a), 0);
    chk("prime_any_b", 32'(any_b), 0);
    chk("prime_pc_a",  32'(pc_a),  0);
    chk("prime_pc_b",  32'(pc_b),  0);

    // settle to 0 and clear anything left from the sync pipeline filling
    sig_a = 1'b0; sig_b = 4'h0;
    step(5);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    chk("clr_pc_a", 32'(pc_a), 0);
    chk("clr_nc_b", 32'(nc_b), 0);

    // rising edge
    sig_a = 1'b1;
    step(LAT);
    chk("rise_pos", 32'(pos_a), 1);
    chk("rise_neg", 32'(neg_a), 0);
    chk("rise_any", 32'(any_a), 1);
    chk("rise_pc",  32'(pc_a),  1);
    step(1);
    chk("rise_pos_end", 32'(pos_a), 0);
    chk("rise_any_end", 32'(any_a), 0);
    chk("rise_pc_hold", 32'(pc_a),  1);

    // falling edge
    sig_a = 1'b0;
    step(LAT);
    chk("fall_neg", 32'(neg_a), 1);
    chk("fall_pos", 32'(pos_a), 0);
    chk("fall_nc",  32'(nc_a),  1);
    step(1);
    chk("fall_neg_end", 32'(neg_a), 0);

    // toggle every cycle for 10 cycles
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig_a = ~sig_a;
      step(1);
      if (i >= LAT - 1) begin
        chk("tog_pos", 32'(pos_a), 32'(((i - LAT + 1) % 2) == 0));
        chk("tog_neg", 32'(neg_a), 32'(((i - LAT + 1) % 2) == 1));
      end
    end
    step(LAT - 1);
    chk("tog_pc", 32'(pc_a), 5);
    chk("tog_nc", 32'(nc_a), 5);
    step(2);
    chk("hold_pos", 32'(pos_a), 0);
    chk("hold_neg", 32'(neg_a), 0);
    chk("hold_pc",  32'(pc_a),  5);

    // saturation on B bit0 (CNT_W=2)
    for (int i = 0; i < 5; i++) begin
      sig_b[0] = 1'b1; step(2);
      sig_b[0] = 1'b0; step(2);
    end
    step(LAT);
    chk("sat_pc_b0", 32'(pc_b[1:0]), 3);
    chk("sat_nc_b0", 32'(nc_b[1:0]), 3);
    chk("sat_pc_b1", 32'(pc_b[3:2]), 0);

    // cnt_clr on the same edge as a pulse on bit1
    sig_b[1] = 1'b1;
    step(LAT - 1);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_edge_pulse", 32'(pos_b), 32'h2);
    chk("clr_edge_pc",    32'(pc_b),  0);
    step(1);
    chk("clr_edge_after", 32'(pc_b),  0);

    // multi-bit
    sig_b = 4'h0; step(LAT + 1);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    sig_b = 4'b0101;
    step(LAT - 1);
    chk("mb_early", 32'(pos_b), 0);
    step(1);
    chk("mb_pos", 32'(pos_b), 32'h5);
    chk("mb_neg", 32'(neg_b), 0);
    chk("mb_any", 32'(any_b), 32'h5);
    chk("mb_pc",  32'(pc_b),  32'h11);
    sig_b = 4'b1010;
    step(LAT);
    chk("mb2_pos", 32'(pos_b), 32'hA);
    chk("mb2_neg", 32'(neg_b), 32'h5);
    chk("mb2_any", 32'(any_b), 32'hF);
    chk("mb2_pc",  32'(pc_b),  32'h55);
    chk("mb2_nc",  32'(nc_b),  32'h11);

    // reset mid-operation: edge during reset is lost, everything clears
    sig_a = 1'b1; reset = 1'b1;
    step(LAT + 1);
    chk("mrst_pos_a", 32'(pos_a), 0);
    chk("mrst_pc_a",  32'(pc_a),  0);
    chk("mrst_pc_b",  32'(pc_b),  0);
    chk("mrst_nc_b",  32'(nc_b),  0);
    reset = 1'b0;
    step(1);
    chk("mrst_prime", 32'(any_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
